mem_arbiter_rr: RTL and testbench

- Parametrised N-channel round-robin arbiter between L1-side burst requesters (I-cache, D-cache, prefetch/extra ports) and one downstream burst memory port (L2, victim cache or physical memory).
- Generalises the fixed two-port IF/MEM arbiter: any channel count and widths, registered downstream outputs, a transaction-locked grant, and starvation-free rotation.

---
 rtl/mem_arbiter_rr_if.sv | 30 +++
 rtl/mem_arbiter_rr.sv | 126 ++++++++++++
 tb/tb_mem_arbiter_rr.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_rr_if.sv
// Signal bundle between L1-side requesters, the round-robin arbiter and the downstream burst memory.
// slave: the arbiter's view; master: the environment (requesters plus memory model).
interface mem_arbiter_rr_if #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 16,
  parameter int BURST_W = 128
);
  logic [N_CH-1:0]         req_read;
  logic [N_CH-1:0]         req_write;
  logic [N_CH*ADDR_W-1:0]  req_address;
  logic [N_CH*BURST_W-1:0] req_wdata;
  logic [N_CH-1:0]         req_resp;
  logic [BURST_W-1:0]      req_rdata;
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDR_W-1:0]       mem_address;
  logic [BURST_W-1:0]      mem_wdata;
  logic                    mem_resp;
  logic [BURST_W-1:0]      mem_rdata;

  modport slave (
    input  req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
    output req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output req_read, req_write, req_address, req_wdata, mem_resp, mem_rdata,
    input  req_resp, req_rdata, mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-channel round-robin arbiter onto one burst memory port, grant locked for a whole transaction.
// Define ARB_STATS_EN to add per-channel wrapping grant counters on the grant_count port.
module mem_arbiter_rr #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 16,
  parameter int BURST_W = 128,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_rr_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0] grant_count
`endif
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   g_reg, g_next;
  logic [IDX_W-1:0]   p_reg, p_next;
  logic               mem_read_reg, mem_read_next;
  logic               mem_write_reg, mem_write_next;
  logic [ADDR_W-1:0]  mem_address_reg, mem_address_next;
  logic [BURST_W-1:0] mem_wdata_reg, mem_wdata_next;

  logic [N_CH-1:0]    active;
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;

  assign active = bus.req_read | bus.req_write;

  // Scan from the farthest candidate back to p+1 so the nearest active channel wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = IDX_W'((int'(p_reg) + k) % N_CH);
      if (active[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    g_next           = g_reg;
    p_next           = p_reg;
    mem_read_next    = mem_read_reg;
    mem_write_next   = mem_write_reg;
    mem_address_next = mem_address_reg;
    mem_wdata_next   = mem_wdata_reg;
    bus.req_resp     = '0;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          state_next       = BUSY;
          g_next           = sel_idx;
          p_next           = sel_idx;
          mem_address_next = bus.req_address[int'(sel_idx)*ADDR_W +: ADDR_W];
          mem_wdata_next   = bus.req_wdata[int'(sel_idx)*BURST_W +: BURST_W];
          mem_write_next   = bus.req_write[sel_idx];
          mem_read_next    = ~bus.req_write[sel_idx];
        end
      end
      BUSY: begin
        bus.req_resp[g_reg] = bus.mem_resp;
        if (bus.mem_resp) begin
          state_next     = DONE;
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
        end
      end
      // Bubble cycle: the released requester's stale request must not be seen in IDLE.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      g_reg           <= '0;
      p_reg           <= IDX_W'(N_CH - 1);
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      mem_address_reg <= '0;
      mem_wdata_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      g_reg           <= g_next;
      p_reg           <= p_next;
      mem_read_reg    <= mem_read_next;
      mem_write_reg   <= mem_write_next;
      mem_address_reg <= mem_address_next;
      mem_wdata_reg   <= mem_wdata_next;
    end
  end

  assign bus.mem_read    = mem_read_reg;
  assign bus.mem_write   = mem_write_reg;
  assign bus.mem_address = mem_address_reg;
  assign bus.mem_wdata   = mem_wdata_reg;
  assign bus.req_rdata   = bus.mem_rdata;

`ifdef ARB_STATS_EN
  logic grant_fire;
  assign grant_fire = (state_reg == IDLE) && sel_found;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_stats
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset)
        cnt_reg <= '0;
      else if (grant_fire && (sel_idx == IDX_W'(gi)))
        cnt_reg <= cnt_reg + 1'b1;
    end
    assign grant_count[gi*CNT_W +: CNT_W] = cnt_reg;
  end
`endif
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level arbitration model.
module tb_mem_arbiter_rr;
  localparam int N_CH    = 4;
  localparam int ADDR_W  = 16;
  localparam int BURST_W = 128;
  localparam int CNT_W   = 4;
  localparam int LOGN    = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.N_CH(N_CH), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();
`ifdef ARB_STATS_EN
  logic [N_CH*CNT_W-1:0] grant_count;
`endif

  mem_arbiter_rr #(.N_CH(N_CH), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the memory port, whether a bubble is pending, last granted channel.
  int                 m_owner = -1;
  bit                 m_bubble = 1'b0;
  int                 m_last = N_CH - 1;
  logic               m_rd = 1'b0;
  logic               m_wr = 1'b0;
  logic [ADDR_W-1:0]  m_addr = '0;
  logic [BURST_W-1:0] m_wdata = '0;
  int                 m_cnt [N_CH];

  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_owner = -1; m_bubble = 1'b0; m_last = N_CH - 1;
      m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
      for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    end else if (m_owner >= 0) begin
      if (bus.mem_resp) begin
        m_owner = -1; m_bubble = 1'b1; m_rd = 1'b0; m_wr = 1'b0;
      end
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else begin
      int c;
      c = -1;
      for (int k = 1; k <= N_CH; k++) begin
        int ch;
        ch = (m_last + k) % N_CH;
        if (c < 0 && (bus.req_read[ch] || bus.req_write[ch])) c = ch;
      end
      if (c >= 0) begin
        m_owner = c;
        m_last  = c;
        m_addr  = bus.req_address[c*ADDR_W +: ADDR_W];
        m_wdata = bus.req_wdata[c*BURST_W +: BURST_W];
        m_wr    = bus.req_write[c];
        m_rd    = !bus.req_write[c];
        m_cnt[c] = (m_cnt[c] + 1) % (1 << CNT_W);
      end
    end
  end

  // Per-cycle comparison and logging of the DUT's observable behaviour.
  bit                 check_en = 1'b0;
  int                 cyc = 0;
  logic [N_CH-1:0]    exp_resp;
  logic [N_CH-1:0]    last_resp = '0;
  logic [BURST_W-1:0] rdata_at_resp = '0;
  logic [N_CH-1:0]    resp_log [LOGN];
  bit                 strobe_log [LOGN];
  int                 dut_grants[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    last_resp = bus.req_resp;
    if (cyc < LOGN) begin
      resp_log[cyc]   = bus.req_resp;
      strobe_log[cyc] = bus.mem_read | bus.mem_write;
    end
    if (bus.req_resp != '0) begin
      rdata_at_resp = bus.req_rdata;
      for (int i = N_CH - 1; i >= 0; i--) if (bus.req_resp[i]) dut_grants.push_back(i);
    end
    if (check_en) begin
      exp_resp = '0;
      if (m_owner >= 0 && bus.mem_resp) exp_resp[m_owner] = 1'b1;
      chk("mem_read", 128'(bus.mem_read), 128'(m_rd));
      chk("mem_write", 128'(bus.mem_write), 128'(m_wr));
      chk("mem_address", 128'(bus.mem_address), 128'(m_addr));
      chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("req_resp", 128'(bus.req_resp), 128'(exp_resp));
      if (exp_resp != '0) chk("req_rdata", bus.req_rdata, bus.mem_rdata);
`ifdef ARB_STATS_EN
      for (int i = 0; i < N_CH; i++)
        chk("grant_count", 128'(grant_count[i*CNT_W +: CNT_W]), 128'(m_cnt[i]));
`endif
    end
  end

  // Stimulus state: requester and memory-responder behaviour.
  bit                 rand_mode = 1'b0;
  bit                 spurious = 1'b0;
  bit [N_CH-1:0]      hold = '0;
  int                 mem_lat = 2;
  int                 resp_wait = -1;
  bit                 fixed_en = 1'b0;
  logic [BURST_W-1:0] fixed_rdata = '0;

  function automatic logic [BURST_W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_CH; i++)
      if (last_resp[i] && !hold[i]) begin
        bus.req_read[i] = 1'b0;
        bus.req_write[i] = 1'b0;
      end
    if (rand_mode) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N_CH; i++)
        if (!bus.req_read[i] && !bus.req_write[i] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 2))
            0:       bus.req_read[i] = 1'b1;
            1:       bus.req_write[i] = 1'b1;
            default: begin bus.req_read[i] = 1'b1; bus.req_write[i] = 1'b1; end
          endcase
          bus.req_address[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
          bus.req_wdata[i*BURST_W +: BURST_W] = rnd128();
        end
    end
    bus.mem_resp = 1'b0;
    if (bus.mem_read || bus.mem_write) begin
      if (resp_wait < 0) resp_wait = (mem_lat >= 0) ? mem_lat : $urandom_range(0, 3);
      if (resp_wait == 0) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = fixed_en ? fixed_rdata : rnd128();
        resp_wait = -1;
      end else begin
        resp_wait--;
      end
    end else begin
      resp_wait = -1;
      if (spurious && $urandom_range(0, 3) == 0) begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rnd128();
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    dut_grants.delete();
  endtask

  task automatic wait_grants(input string name, input int n, input int bound);
    for (int k = 0; k < bound && dut_grants.size() < n; k++) step();
    chk(name, 128'(dut_grants.size() >= n), 128'(1));
  endtask

  task automatic drop_all();
    hold = '0;
    bus.req_read = '0;
    bus.req_write = '0;
  endtask

  initial begin
    int start;
    int resp_cycles[$];
    int n_resp;
    int exp2 [4] = '{0, 1, 0, 1};
    int exp5 [6] = '{1, 3, 1, 2, 3, 1};

    bus.req_read = '0; bus.req_write = '0; bus.req_address = '0; bus.req_wdata = '0;
    bus.mem_resp = 1'b0; bus.mem_rdata = '0;
    step();
    check_en = 1'b1;
    do_reset();

    // Reset state, and mem_resp outside BUSY has no effect.
    bus.mem_resp = 1'b1;
    #1;
    chk("rst_req_resp", 128'(bus.req_resp), 128'(0));
    chk("rst_mem_read", 128'(bus.mem_read), 128'(0));
    chk("rst_mem_write", 128'(bus.mem_write), 128'(0));
    chk("rst_mem_address", 128'(bus.mem_address), 128'(0));
    step();
    chk("idle_resp_ignored", 128'(bus.mem_read | bus.mem_write), 128'(0));

    // Single read on ch1, response five cycles after the request.
    do_reset();
    mem_lat = 4; fixed_en = 1'b1; fixed_rdata = {16{8'hA5}};
    bus.req_read[1] = 1'b1;
    bus.req_address[1*ADDR_W +: ADDR_W] = 16'h1230;
    start = cyc;
    step();
    chk("t1_mem_read", 128'(bus.mem_read), 128'(1));
    chk("t1_mem_address", 128'(bus.mem_address), 128'(16'h1230));
    repeat (12) step();
    n_resp = 0;
    for (int c = start + 1; c <= cyc; c++) if (resp_log[c] != '0) n_resp++;
    chk("t1_resp_count", 128'(n_resp), 128'(1));
    chk("t1_resp_vector", 128'((dut_grants.size() > 0) ? dut_grants[0] : -1), 128'(1));
    chk("t1_rdata", rdata_at_resp, {16{8'hA5}});
    fixed_en = 1'b0;

    // ch0 and ch1 reading back to back: alternating grants and the bubble timing.
    do_reset();
    mem_lat = 1; hold[0] = 1'b1; hold[1] = 1'b1;
    bus.req_read[0] = 1'b1; bus.req_read[1] = 1'b1;
    start = cyc;
    wait_grants("t2_grants_seen", 4, 100);
    drop_all();
    step();
    for (int k = 0; k < 4; k++)
      chk("t2_grant_order", 128'((dut_grants.size() > k) ? dut_grants[k] : -1), 128'(exp2[k]));
    resp_cycles.delete();
    for (int c = start + 1; c <= cyc; c++) if (resp_log[c] != '0) resp_cycles.push_back(c);
    for (int k = 0; k < 3 && k < resp_cycles.size(); k++) begin
      chk("t2_strobe_r1", 128'(strobe_log[resp_cycles[k] + 1]), 128'(0));
      chk("t2_strobe_r2", 128'(strobe_log[resp_cycles[k] + 2]), 128'(0));
      chk("t2_strobe_r3", 128'(strobe_log[resp_cycles[k] + 3]), 128'(1));
    end

    // Read and write together on ch0: write wins.
    do_reset();
    mem_lat = 2;
    bus.req_read[0] = 1'b1; bus.req_write[0] = 1'b1;
    bus.req_wdata[0 +: BURST_W] = 128'h1;
    step();
    chk("t3_mem_write", 128'(bus.mem_write), 128'(1));
    chk("t3_mem_read", 128'(bus.mem_read), 128'(0));
    chk("t3_mem_wdata", bus.mem_wdata, 128'h1);
    wait_grants("t3_done", 1, 20);
    step(); step();

    // Reset two cycles into a BUSY write on ch0 abandons it; ch0 then wins again.
    do_reset();
    mem_lat = 50;
    bus.req_write[0] = 1'b1;
    bus.req_wdata[0 +: BURST_W] = 128'hBEEF;
    step();
    chk("t4_busy_write", 128'(bus.mem_write), 128'(1));
    step();
    reset = 1'b1;
    step();
    chk("t4_write_dropped", 128'(bus.mem_write), 128'(0));
    chk("t4_no_resp", 128'(bus.req_resp), 128'(0));
    chk("t4_no_grant_logged", 128'(dut_grants.size()), 128'(0));
    reset = 1'b0; mem_lat = 2;
    bus.req_read[1] = 1'b1;
    wait_grants("t4_regrant", 2, 40);
    chk("t4_first_after_reset", 128'((dut_grants.size() > 0) ? dut_grants[0] : -1), 128'(0));
    chk("t4_second_after_reset", 128'((dut_grants.size() > 1) ? dut_grants[1] : -1), 128'(1));
    drop_all();
    step(); step();

    // Four channels: ch1 then ch3 contend, ch2 joins late and is served before ch1 again.
    do_reset();
    mem_lat = 1; hold = 4'b1110;
    bus.req_read[1] = 1'b1;
    wait_grants("t5_setup", 1, 30);
    bus.req_read[3] = 1'b1;
    wait_grants("t5_pair", 3, 60);
    bus.req_read[2] = 1'b1;
    wait_grants("t5_join", 6, 100);
    drop_all();
    step(); step();
    for (int k = 0; k < 6; k++)
      chk("t5_grant_order", 128'((dut_grants.size() > k) ? dut_grants[k] : -1), 128'(exp5[k]));

`ifdef ARB_STATS_EN
    // ch0 alone for 17 transactions: its 4-bit counter wraps to 1.
    do_reset();
    mem_lat = 0; hold[0] = 1'b1;
    bus.req_read[0] = 1'b1;
    wait_grants("t6_seventeen", 17, 400);
    drop_all();
    step(); step(); step();
    chk("t6_count0", 128'(grant_count[0 +: CNT_W]), 128'(1));
    chk("t6_count1", 128'(grant_count[CNT_W +: CNT_W]), 128'(0));
`endif

    // Randomized traffic with spurious responses and occasional resets.
    do_reset();
    mem_lat = -1; spurious = 1'b1; rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0; spurious = 1'b0; reset = 1'b0;
    chk("rand_activity", 128'(dut_grants.size() > 20), 128'(1));

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
